// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor front end and the relay FSM that consumes it:
// conditioner state encoding and the default sample width.
package sensor_pkg;

  localparam int DEFAULT_DATA_W = 12;

  typedef enum logic [1:0] {
    ST_UNCAL = 2'd0,
    ST_CAL   = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/pow2_averager.sv
// Accumulates 2^LOG2N strobed values and presents their truncated mean together
// with a done pulse, both combinational on the strobe that completes the window.
module pow2_averager #(
  parameter int WIDTH = 12,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] mean,
  output logic             done
);

  localparam int ACC_W = WIDTH + LOG2N;

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [LOG2N-1:0] cnt_q, cnt_d;

  // The sum of 2^LOG2N values of WIDTH bits always fits in ACC_W bits.
  assign sum  = acc_q + {{LOG2N{1'b0}}, in_data};
  assign mean = sum[ACC_W-1:LOG2N];
  assign done = in_valid && !clr && (cnt_q == '1);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      acc_d = done ? '0 : sum;
      cnt_d = cnt_q + LOG2N'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Sensor front end: boxcar-averages ADC samples, captures a calibrated reference
// on request and flags a sensor stuck at either rail.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int AVG_LOG2  = 3,
  parameter int CAL_LOG2  = 2,
  parameter int SAT_COUNT = 4
) (
  input  logic              clk_16ms,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              cal_req,
  output logic [DATA_W-1:0] sen,
  output logic [DATA_W-1:0] sen_ref,
  output logic              sen_valid,
  output logic              ref_valid,
  output logic              busy_cal,
  output logic              sat_err
);

  localparam int SAT_W = $clog2(SAT_COUNT + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sen_q, sen_d, sen_ref_q, sen_ref_d;
  logic              sen_valid_q, sen_valid_d, ref_valid_q, ref_valid_d;
  logic              busy_cal_q, busy_cal_d, sat_err_q, sat_err_d;
  logic [SAT_W-1:0]  sat_cnt_q, sat_cnt_d;

  logic              win_clr, win_done, cal_done, is_rail;
  logic [DATA_W-1:0] win_mean, cal_mean;

  // A taken request clears both accumulators and swallows any coincident sample.
  assign win_clr = cal_req && (state_q != ST_CAL);
  assign is_rail = (adc_data == '0) || (adc_data == '1);

  pow2_averager #(.WIDTH(DATA_W), .LOG2N(AVG_LOG2)) u_win (
    .clk      (clk_16ms),
    .rst_n    (rst_n),
    .clr      (win_clr),
    .in_valid (adc_valid),
    .in_data  (adc_data),
    .mean     (win_mean),
    .done     (win_done)
  );

  pow2_averager #(.WIDTH(DATA_W), .LOG2N(CAL_LOG2)) u_cal (
    .clk      (clk_16ms),
    .rst_n    (rst_n),
    .clr      (win_clr),
    .in_valid (win_done && (state_q == ST_CAL)),
    .in_data  (win_mean),
    .mean     (cal_mean),
    .done     (cal_done)
  );

  always_comb begin
    state_d     = state_q;
    sen_d       = sen_q;
    sen_ref_d   = sen_ref_q;
    sen_valid_d = 1'b0;
    ref_valid_d = ref_valid_q;
    sat_cnt_d   = sat_cnt_q;

    if (adc_valid) begin
      if (!is_rail)                              sat_cnt_d = '0;
      else if (sat_cnt_q != SAT_W'(SAT_COUNT))   sat_cnt_d = sat_cnt_q + SAT_W'(1);
    end
    sat_err_d = (sat_cnt_d == SAT_W'(SAT_COUNT));

    if (win_done) sen_d = win_mean;

    case (state_q)
      ST_UNCAL: if (win_clr) state_d = ST_CAL;
      ST_CAL: begin
        if (cal_done) begin
          sen_ref_d   = cal_mean;
          ref_valid_d = 1'b1;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (win_clr) begin
          state_d     = ST_CAL;
          ref_valid_d = 1'b0;
        end else if (win_done) begin
          sen_valid_d = 1'b1;
        end
      end
      default: state_d = ST_UNCAL;
    endcase

    busy_cal_d = (state_d == ST_CAL);
  end

  always_ff @(posedge clk_16ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNCAL;
      sen_q       <= '0;
      sen_ref_q   <= '0;
      sen_valid_q <= 1'b0;
      ref_valid_q <= 1'b0;
      busy_cal_q  <= 1'b0;
      sat_err_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sen_q       <= sen_d;
      sen_ref_q   <= sen_ref_d;
      sen_valid_q <= sen_valid_d;
      ref_valid_q <= ref_valid_d;
      busy_cal_q  <= busy_cal_d;
      sat_err_q   <= sat_err_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign sen       = sen_q;
  assign sen_ref   = sen_ref_q;
  assign sen_valid = sen_valid_q;
  assign ref_valid = ref_valid_q;
  assign busy_cal  = busy_cal_q;
  assign sat_err   = sat_err_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed and randomized checks of sensor_conditioner against a queue-based
// behavioural model of windowing, calibration and rail detection.
module tb_sensor_conditioner;

  localparam int DATA_W = 12;
  localparam int WIN_N  = 8;
  localparam int CAL_N  = 4;
  localparam int SAT_N  = 4;
  localparam int RAIL_HI = (1 << DATA_W) - 1;

  logic              clk_16ms = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] adc_data;
  logic              adc_valid, cal_req;
  logic [DATA_W-1:0] sen, sen_ref;
  logic              sen_valid, ref_valid, busy_cal, sat_err;

  int n_assert = 0;
  int n_fail   = 0;

  // model state: mode 0=uncalibrated, 1=calibrating, 2=running
  int mode, run_len;
  int win_q[$];
  int cal_q[$];
  int exp_sen, exp_ref, exp_sv, exp_rv, exp_busy, exp_sat;

  sensor_conditioner #(.DATA_W(DATA_W), .AVG_LOG2(3), .CAL_LOG2(2), .SAT_COUNT(SAT_N)) dut (
    .clk_16ms  (clk_16ms),
    .rst_n     (rst_n),
    .adc_data  (adc_data),
    .adc_valid (adc_valid),
    .cal_req   (cal_req),
    .sen       (sen),
    .sen_ref   (sen_ref),
    .sen_valid (sen_valid),
    .ref_valid (ref_valid),
    .busy_cal  (busy_cal),
    .sat_err   (sat_err)
  );

  always #5 clk_16ms = ~clk_16ms;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sen", int'(sen), exp_sen);
    chk("sen_ref", int'(sen_ref), exp_ref);
    chk("sen_valid", int'(sen_valid), exp_sv);
    chk("ref_valid", int'(ref_valid), exp_rv);
    chk("busy_cal", int'(busy_cal), exp_busy);
    chk("sat_err", int'(sat_err), exp_sat);
  endtask

  task automatic model_reset();
    mode = 0; run_len = 0;
    win_q.delete(); cal_q.delete();
    exp_sen = 0; exp_ref = 0; exp_sv = 0; exp_rv = 0; exp_busy = 0; exp_sat = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c);
    int sum;
    exp_sv = 0;
    if (v) begin
      if (d == 0 || d == RAIL_HI) run_len = (run_len < SAT_N) ? run_len + 1 : SAT_N;
      else run_len = 0;
    end
    exp_sat = (run_len == SAT_N);
    if (c && mode != 1) begin
      mode = 1; exp_busy = 1; exp_rv = 0;
      win_q.delete(); cal_q.delete();
      return;
    end
    if (!v) return;
    win_q.push_back(d);
    if (win_q.size() < WIN_N) return;
    sum = 0;
    foreach (win_q[i]) sum += win_q[i];
    win_q.delete();
    exp_sen = sum / WIN_N;
    if (mode == 2) exp_sv = 1;
    if (mode == 1) begin
      cal_q.push_back(exp_sen);
      if (cal_q.size() == CAL_N) begin
        sum = 0;
        foreach (cal_q[i]) sum += cal_q[i];
        cal_q.delete();
        exp_ref = sum / CAL_N; exp_rv = 1; exp_busy = 0; mode = 2;
      end
    end
  endtask

  task automatic step(input bit v, input int d, input bit c);
    adc_valid = v; adc_data = DATA_W'(d); cal_req = c;
    @(posedge clk_16ms); #1;
    model_step(v, d, c);
    check_all();
    adc_valid = 1'b0; cal_req = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("state_uncal", int'(dut.state_q), 0);
    @(posedge clk_16ms); #1;
    rst_n = 1'b1;
  endtask

  // Feeds n accepted samples of value d with random idle gaps between them.
  task automatic feed_gappy(input int n, input int d);
    int got = 0;
    while (got < n) begin
      if ($urandom_range(0, 2) == 0) step(1'b0, 0, 1'b0);
      else begin step(1'b1, d, 1'b0); got++; end
    end
  endtask

  initial begin
    int k, d;
    rst_n = 1'b0; adc_valid = 1'b0; adc_data = '0; cal_req = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_16ms);
    #1;
    do_reset();

    // reset mid-window, then an uncalibrated window
    for (int i = 0; i < 5; i++) step(1'b1, 300 + i, 1'b0);
    do_reset();
    for (int i = 0; i < WIN_N; i++) step(1'b1, 100, 1'b0);
    chk("uncal_sen_100", int'(sen), 100);
    chk("uncal_state", int'(dut.state_q), 0);

    // calibration with gaps
    step(1'b0, 0, 1'b1);
    chk("busy_after_req", int'(busy_cal), 1);
    feed_gappy(31, 1000);
    step(1'b1, 1000, 1'b0);
    chk("cal_ref_1000", int'(sen_ref), 1000);
    chk("cal_ref_valid", int'(ref_valid), 1);
    chk("cal_busy_fall", int'(busy_cal), 0);

    // averaging with truncation
    for (int i = 0; i < WIN_N; i++) step(1'b1, 1000 + i, 1'b0);
    chk("avg_1003", int'(sen), 1003);
    chk("avg_pulse", int'(sen_valid), 1);
    step(1'b0, 0, 1'b0);
    chk("avg_pulse_one_cycle", int'(sen_valid), 0);

    // mid-window recalibration with a coincident sample
    for (int i = 0; i < 5; i++) step(1'b1, 500, 1'b0);
    step(1'b1, 3000, 1'b1);
    chk("recal_ref_invalid", int'(ref_valid), 0);
    chk("recal_ref_held", int'(sen_ref), 1000);
    feed_gappy(32, 2000);
    chk("recal_ref_2000", int'(sen_ref), 2000);

    // cal_req on the edge completing a RUN window
    for (int i = 0; i < WIN_N - 1; i++) step(1'b1, 700, 1'b0);
    step(1'b1, 700, 1'b1);
    chk("req_on_done_no_pulse", int'(sen_valid), 0);
    feed_gappy(32, 1500);

    // saturation
    for (int i = 0; i < 3; i++) step(1'b1, 0, 1'b0);
    chk("sat_three_low", int'(sat_err), 0);
    step(1'b1, RAIL_HI, 1'b0);
    chk("sat_fourth", int'(sat_err), 1);
    step(1'b1, 2000, 1'b0);
    chk("sat_clear", int'(sat_err), 0);
    for (int i = 0; i < 3; i++) step(1'b1, RAIL_HI, 1'b0);
    step(1'b1, 0, 1'b1);
    chk("sat_with_cal_req", int'(sat_err), 1);
    feed_gappy(32, 800);

    // randomized traffic, with one reset in the middle
    for (int n = 0; n < 600; n++) begin
      k = $urandom_range(0, 9);
      d = (k == 0) ? 0 : (k == 1) ? RAIL_HI : $urandom_range(0, RAIL_HI);
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 60) == 0);
      if (n == 300) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
